// File: rtl/capture_sequencer.sv
// Capture sequencer: steps the sample FIFO through clear, pre-trigger fill, trigger window, post-trigger fill and readout.
// Optional build macro SEQ_TRIG_DELAY_EN adds the trig_delay output (valid samples seen while waiting for trigger).
module capture_sequencer #(
  parameter int PTR_W = 15,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             arm,
  input  logic             abort,
  input  logic [PTR_W-1:0] pretrig_len,
  input  logic [PTR_W:0]   posttrig_len,
  input  logic             sample_valid,
  input  logic             trigger,
  input  logic             rd_ready,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  output logic             fifo_en,
  output logic             fifo_rnw,
  output logic             fifo_clear,
  output logic             fifo_hold_window,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state_o
`ifdef SEQ_TRIG_DELAY_EN
  ,
  output logic [CNT_W-1:0] trig_delay
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_PRE   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_POST  = 3'd4,
    ST_READ  = 3'd5
  } state_t;

  localparam logic [PTR_W:0] CNT_ONE = {{PTR_W{1'b0}}, 1'b1};

  state_t           state_r, state_s, fsm_nxt_s;
  logic             abort_pend_r, abort_pend_s, pend_nxt_s, abort_hit_s;
  logic [PTR_W-1:0] pre_len_r;
  logic [PTR_W:0]   post_len_r;
  logic [PTR_W:0]   wr_cnt_r, wr_cnt_s, cnt_inc_s;
  logic             done_r, busy_r;

  assign abort_hit_s  = abort && (state_r != ST_IDLE);
  // An abort while already clearing needs no second clear pulse.
  assign state_s      = abort_hit_s ? ((state_r == ST_CLEAR) ? ST_IDLE : ST_CLEAR) : fsm_nxt_s;
  assign abort_pend_s = abort_hit_s ? 1'b1 : pend_nxt_s;
  assign cnt_inc_s    = wr_cnt_r + CNT_ONE;

  // Next-state, write counter and FIFO control decode.
  always_comb begin
    fsm_nxt_s        = state_r;
    pend_nxt_s       = abort_pend_r;
    wr_cnt_s         = wr_cnt_r;
    fifo_en          = 1'b0;
    fifo_rnw         = 1'b1;
    fifo_clear       = 1'b0;
    fifo_hold_window = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (arm) begin
          fsm_nxt_s  = ST_CLEAR;
          pend_nxt_s = 1'b0;
          wr_cnt_s   = '0;
        end else begin
          fsm_nxt_s  = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        fifo_clear = 1'b1;
        wr_cnt_s   = '0;
        if (abort_pend_r) begin
          fsm_nxt_s = ST_IDLE;
        end else if (pre_len_r != '0) begin
          fsm_nxt_s = ST_PRE;
        end else begin
          fsm_nxt_s = ST_WAIT;
        end
      end
      ST_PRE: begin
        fifo_en  = sample_valid;
        fifo_rnw = 1'b0;
        if (sample_valid) begin
          wr_cnt_s = cnt_inc_s;
          if (cnt_inc_s == {1'b0, pre_len_r}) begin
            fsm_nxt_s = ST_WAIT;
          end else begin
            fsm_nxt_s = ST_PRE;
          end
        end else begin
          fsm_nxt_s = ST_PRE;
        end
      end
      ST_WAIT: begin
        // Each write also retires the oldest sample, so the window slides at constant depth.
        fifo_en          = sample_valid;
        fifo_rnw         = 1'b0;
        fifo_hold_window = 1'b1;
        wr_cnt_s         = '0;
        if (trigger) begin
          fsm_nxt_s = (post_len_r == '0) ? ST_READ : ST_POST;
        end else begin
          fsm_nxt_s = ST_WAIT;
        end
      end
      ST_POST: begin
        fifo_en  = sample_valid & ~fifo_full;
        fifo_rnw = 1'b0;
        if (fifo_full) begin
          fsm_nxt_s = ST_READ;
        end else if (sample_valid) begin
          wr_cnt_s  = cnt_inc_s;
          fsm_nxt_s = (cnt_inc_s == post_len_r) ? ST_READ : ST_POST;
        end else begin
          fsm_nxt_s = ST_POST;
        end
      end
      ST_READ: begin
        fifo_en  = rd_ready & ~fifo_empty;
        fifo_rnw = 1'b1;
        if (fifo_empty) begin
          fsm_nxt_s = ST_IDLE;
        end else begin
          fsm_nxt_s = ST_READ;
        end
      end
      default: begin
        fsm_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, latched lengths, counter and registered status flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      abort_pend_r <= 1'b0;
      pre_len_r    <= '0;
      post_len_r   <= '0;
      wr_cnt_r     <= '0;
      done_r       <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      abort_pend_r <= abort_pend_s;
      wr_cnt_r     <= wr_cnt_s;
      done_r       <= (state_s == ST_READ) && (state_r != ST_READ);
      busy_r       <= (state_s != ST_IDLE);
      if ((state_r == ST_IDLE) && arm) begin
        pre_len_r  <= pretrig_len;
        post_len_r <= posttrig_len;
      end else begin
        pre_len_r  <= pre_len_r;
        post_len_r <= post_len_r;
      end
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign state_o = state_r;

`ifdef SEQ_TRIG_DELAY_EN
  localparam logic [CNT_W-1:0] DLY_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  logic [CNT_W-1:0] dly_r;

  // Saturating count of valid samples in WAIT before the trigger; frozen until the next clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dly_r <= '0;
    end else if (state_r == ST_CLEAR) begin
      dly_r <= '0;
    end else if ((state_r == ST_WAIT) && sample_valid && !trigger && (dly_r != '1)) begin
      dly_r <= dly_r + DLY_ONE;
    end else begin
      dly_r <= dly_r;
    end
  end

  assign trig_delay = dly_r;
`else
  // CNT_W only sizes the optional delay counter.
  logic [CNT_W-1:0] unused_trig_delay_s;
  assign unused_trig_delay_s = '0;
`endif

endmodule

// File: tb/tb_capture_sequencer.sv
// Randomised scoreboard bench for capture_sequencer with a queue-based FIFO model and readout checker.
module tb_capture_sequencer;
  localparam int PTR_W = 15;
  localparam int CNT_W = 32;
  localparam int CAP   = 1 << PTR_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n, arm, abort, sample_valid, trigger, rd_ready;
  logic             fifo_full = 1'b0;
  logic             fifo_empty = 1'b1;
  logic [PTR_W-1:0] pretrig_len;
  logic [PTR_W:0]   posttrig_len;
  logic             fifo_en, fifo_rnw, fifo_clear, fifo_hold_window, busy, done;
  logic [2:0]       state_o;
  logic [7:0]       data_in;
`ifdef SEQ_TRIG_DELAY_EN
  logic [CNT_W-1:0] trig_delay;
`endif

  capture_sequencer #(.PTR_W(PTR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .arm(arm), .abort(abort),
    .pretrig_len(pretrig_len), .posttrig_len(posttrig_len),
    .sample_valid(sample_valid), .trigger(trigger), .rd_ready(rd_ready),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_en(fifo_en), .fifo_rnw(fifo_rnw), .fifo_clear(fifo_clear),
    .fifo_hold_window(fifo_hold_window), .busy(busy), .done(done), .state_o(state_o)
`ifdef SEQ_TRIG_DELAY_EN
    , .trig_delay(trig_delay)
`endif
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit mon_on = 1'b0;
  byte unsigned fifo_q[$];
  byte unsigned exp_q[$];
  logic s_en = 1'b0, s_rnw = 1'b1, s_clear = 1'b0, s_hold = 1'b0;
  logic [7:0] s_data = 8'd0;
  logic rd_dv = 1'b0;
  logic [7:0] rd_data = 8'd0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples FIFO controls mid-cycle, checks invariants and scores readout bytes.
  always @(negedge clk) begin
    s_en    <= fifo_en;
    s_rnw   <= fifo_rnw;
    s_clear <= fifo_clear;
    s_hold  <= fifo_hold_window;
    s_data  <= data_in;
    if (mon_on) begin
      chk("en_with_clear", longint'(fifo_en & fifo_clear), 0);
      chk("write_when_full", longint'(fifo_en & ~fifo_rnw & fifo_full), 0);
      chk("busy_vs_state", longint'(busy), longint'(state_o != 3'd0));
      if (done) begin
        done_cnt++;
        chk("done_state", longint'(state_o), 5);
      end
      if (rd_dv) begin
        if (exp_q.size() == 0) chk("unexpected_read", 1, 0);
        else chk("read_data", longint'(rd_data), longint'(exp_q.pop_front()));
      end
    end
  end

  // FIFO model: acts at the clock edge on controls sampled during the cycle.
  always @(posedge clk) begin
    rd_dv <= 1'b0;
    if (s_clear) begin
      fifo_q.delete();
    end else if (s_en && !s_rnw) begin
      if (fifo_q.size() < CAP) fifo_q.push_back(s_data);
      if (s_hold) void'(fifo_q.pop_front());
    end else if (s_en && s_rnw && (fifo_q.size() > 0)) begin
      rd_data <= fifo_q.pop_front();
      rd_dv   <= 1'b1;
    end
    fifo_full  <= (fifo_q.size() == CAP);
    fifo_empty <= (fifo_q.size() == 0);
  end

  // mode 0: normal capture, 1: abort during POST, 2: reset during READ
  task automatic capture(input int pre, input int post, input int vprob, input int trig_after,
                         input int tprob, input int rprob, input int mode);
    byte unsigned win[$];
    byte unsigned postq[$];
    int nv = 0, cyc = 0, n = 0, wait_valid = 0, lim, done_base;
    bit trig_seen = 1'b0, complete = 1'b0;
    lim = (post < CAP - pre) ? post : CAP - pre;
    done_base = done_cnt;
    @(posedge clk); #1;
    pretrig_len = pre[PTR_W-1:0];
    posttrig_len = post[PTR_W:0];
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
    sample_valid = 1'b0;
    trigger = 1'b0;
    @(negedge clk);
    chk("clear_state", longint'(state_o), 1);
    chk("clear_pulse", longint'(fifo_clear), 1);
    @(posedge clk); #1;
    while (!complete && cyc < 40000) begin
      if (mode == 1 && trig_seen) begin
        abort = 1'b1;
        sample_valid = 1'b0;
        break;
      end
      sample_valid = ($urandom_range(99) < vprob);
      data_in = 8'($urandom);
      trigger = (cyc >= trig_after) && ($urandom_range(99) < tprob);
      if (!trig_seen) begin
        // Trigger counts only once pre samples have been stored; its own sample is pre-trigger.
        if (trigger && nv >= pre) begin
          trig_seen = 1'b1;
          if (lim == 0) complete = 1'b1;
        end else if (sample_valid && nv >= pre) begin
          wait_valid++;
        end
        if (sample_valid) begin
          win.push_back(data_in);
          nv++;
          while (win.size() > pre) void'(win.pop_front());
        end
      end else if (sample_valid) begin
        postq.push_back(data_in);
        if (postq.size() == lim) complete = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (mode == 1) begin
      @(negedge clk);
      chk("abort_from_post", longint'(state_o), 4);
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("abort_clear_state", longint'(state_o), 1);
      chk("abort_clear_pulse", longint'(fifo_clear), 1);
      @(negedge clk);
      chk("abort_idle", longint'(state_o), 0);
      chk("abort_fifo_empty", longint'(fifo_empty), 1);
      chk("abort_no_done", done_cnt - done_base, 0);
      return;
    end
    chk("capture_timeout", longint'(complete), 1);
    foreach (win[i]) exp_q.push_back(win[i]);
    foreach (postq[i]) exp_q.push_back(postq[i]);
    while (n < 80000) begin
      rd_ready = ($urandom_range(99) < rprob);
      sample_valid = 1'b1;
      data_in = 8'($urandom);
      trigger = 1'($urandom_range(1));
      @(negedge clk);
      if (mode == 2 && state_o == 3'd5 && n >= 4) begin
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_state", longint'(state_o), 0);
        chk("rst_rnw", longint'(fifo_rnw), 1);
        chk("rst_en", longint'(fifo_en), 0);
        chk("rst_busy", longint'(busy), 0);
        @(negedge clk);
        exp_q.delete();
        chk("rst_done_count", done_cnt - done_base, 1);
        rd_ready = 1'b0;
        return;
      end
      if (state_o == 3'd0) break;
      @(posedge clk); #1;
      n++;
    end
    chk("readout_timeout", longint'(n < 80000), 1);
    rd_ready = 1'b0;
    @(negedge clk);
    chk("readout_left", exp_q.size(), 0);
    chk("done_count", done_cnt - done_base, 1);
`ifdef SEQ_TRIG_DELAY_EN
    chk("trig_delay", longint'(trig_delay), wait_valid);
`endif
    exp_q.delete();
  endtask

  initial begin
    reset_n = 1'b0; arm = 1'b0; abort = 1'b0; sample_valid = 1'b0; trigger = 1'b0;
    rd_ready = 1'b0; data_in = 8'd0; pretrig_len = '0; posttrig_len = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", longint'(state_o), 0);
    chk("reset_busy", longint'(busy), 0);
    chk("reset_done", longint'(done), 0);
    chk("reset_en", longint'(fifo_en), 0);
    chk("reset_rnw", longint'(fifo_rnw), 1);
    chk("reset_clear", longint'(fifo_clear), 0);
    chk("reset_hold", longint'(fifo_hold_window), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_on = 1'b1;
    capture(4, 6, 100, 13, 100, 100, 0);
    capture(0, 0, 100, 0, 100, 100, 0);
    capture(2, 5, 100, 9, 100, 100, 0);
    for (int i = 0; i < 10; i++) begin
      capture($urandom_range(20), $urandom_range(30), $urandom_range(100, 30),
              $urandom_range(30), $urandom_range(100, 20), $urandom_range(100, 30), 0);
    end
    capture(5, 200, 80, 3, 50, 80, 1);
    capture(8, 20, 100, 0, 100, 50, 2);
    capture(3, 4, 70, 2, 60, 60, 0);
    capture(100, 32768, 100, 0, 100, 100, 0);
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
